// File: rtl/amq_pkg.sv
// Shared constants, state encoding and buffer entry layout for the
// A-mod-Q result drain.
package amq_pkg;

  // Result geometry
  localparam int W         = 118;  // result word width
  localparam int WORDS     = 4;    // words per reduced result
  localparam int AW        = 2;    // result address width
  localparam int RD_LAT    = 1;    // result RAM read latency
  localparam int BUF_DEPTH = 2;    // prefetch buffer entries (>= RD_LAT+1)

  // Width of the buffer occupancy counter (0..BUF_DEPTH)
  localparam int CNTW = $clog2(BUF_DEPTH + 1);

  // Drain controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    REL   = 2'd3
  } drain_state_t;

  // One prefetch buffer entry: word, its index and the last-word marker
  typedef struct packed {
    logic          last;
    logic [AW-1:0] idx;
    logic [W-1:0]  data;
  } drain_entry_t;

  localparam int ENTRY_W = $bits(drain_entry_t);

  // True for the index of the final word of a result
  function automatic logic is_last_idx(input logic [AW-1:0] idx);
    return idx == AW'(WORDS - 1);
  endfunction

endpackage

// File: rtl/amq_drain_fifo.sv
// Small synchronous prefetch FIFO. Entries shift towards slot 0 on a pop so
// the head is always a plain register (no read mux, no path from the pop
// request to the output data). Push and pop in the same cycle are allowed
// even when full.
module amq_drain_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int CW    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic [DEPTH-1:0][DW-1:0] w_mem_next;
  logic [CW-1:0]            r_count;
  logic                     w_pop;
  logic                     w_push;
  logic [CW-1:0]            w_wpos;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[0];

  // A pop frees the head slot this cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // After a pop everything moves down one slot, so the write lands one lower
  assign w_wpos = w_pop ? (r_count - CW'(1)) : r_count;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi < DEPTH - 1) begin : g_mid
        assign w_mem_next[gi] = (w_push && (w_wpos == CW'(gi))) ? i_din :
                                w_pop ? r_mem[gi+1] : r_mem[gi];
      end else begin : g_tail
        assign w_mem_next[gi] = (w_push && (w_wpos == CW'(gi))) ? i_din :
                                r_mem[gi];
      end
    end
  endgenerate

  // Storage update; cleared on reset so the head reads zero afterwards
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem <= '0;
    end else begin
      r_mem <= w_mem_next;
    end
  end

  // Occupancy tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/amq_result_drain.sv
// Drains the A-mod-Q reducer's multi-word result RAM onto a valid/ready
// stream, LSW first, tagging the burst with the centred-lift flag and
// pulsing RELEASE once the final word has been accepted.
module amq_result_drain
  import amq_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          DONE_AmQ,
  input  logic          CENTRAL_L_HAPPENED,
  output logic [AW-1:0] RD_RES_ADDR,
  input  logic [W-1:0]  D_RES,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic [W-1:0]  M_DATA,
  output logic [AW-1:0] M_IDX,
  output logic          M_LAST,
  output logic          M_CENTRAL,
  output logic          BUSY,
  output logic          RELEASE,
  output logic          OVERRUN
);

  // Wide enough for buffer occupancy plus every in-flight read
  localparam int CMW = $clog2(BUF_DEPTH + RD_LAT + 2);

  drain_state_t              r_state;
  logic                      r_done_prev;
  logic                      r_busy;
  logic                      r_release;
  logic                      r_overrun;
  logic                      r_central;
  logic [AW-1:0]             r_rd_addr;
  logic [RD_LAT-1:0]         r_pipe_vld;
  logic [RD_LAT-1:0][AW-1:0] r_pipe_idx;

  logic                      w_done_rise;
  logic                      w_issue;
  logic                      w_can_issue;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [CNTW-1:0]           w_fifo_count;
  drain_entry_t              w_push_entry;
  drain_entry_t              w_head;
  logic [CMW-1:0]            w_inflight;
  logic [CMW-1:0]            w_commit;

  assign w_done_rise = DONE_AmQ && !r_done_prev;
  assign w_pop       = !w_fifo_empty && M_READY;

  // Count reads whose data has not yet reached the buffer
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CMW'(r_pipe_vld[i]);
    end
  end

  // Buffer space already promised: stored words plus reads in flight. A
  // word leaving the head this cycle hands its slot straight back, which is
  // what lets a two-entry buffer sustain one word per cycle.
  assign w_commit    = CMW'(w_fifo_count) + w_inflight - CMW'(w_pop);
  assign w_can_issue = (w_commit < CMW'(BUF_DEPTH)) && !(w_fifo_full && !w_pop);

  // RD_RES_ADDR always shows the next address to read; the RAM samples it on
  // the edge where the read is issued, so the first address is presented as
  // soon as the burst starts.
  assign w_issue = (r_state == READ) && w_can_issue;

  // Word arriving from the RAM at the tail of the read pipeline
  assign w_push            = r_pipe_vld[RD_LAT-1];
  assign w_push_entry.data = D_RES;
  assign w_push_entry.idx  = r_pipe_idx[RD_LAT-1];
  assign w_push_entry.last = is_last_idx(r_pipe_idx[RD_LAT-1]);

  amq_drain_fifo #(
    .DEPTH (BUF_DEPTH),
    .DW    (ENTRY_W),
    .CW    (CNTW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Read pipeline: shift the valid/index of each issued read until its data lands
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pipe_vld <= '0;
      r_pipe_idx <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_idx[0] <= r_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  // Burst controller: start on DONE rise, issue reads, wait for the last
  // word to leave, then pulse RELEASE for one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_done_prev <= 1'b0;
      r_busy      <= 1'b0;
      r_release   <= 1'b0;
      r_overrun   <= 1'b0;
      r_central   <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_done_prev <= DONE_AmQ;
      r_release   <= 1'b0;

      // A rise that cannot start a burst (anything but IDLE, including the
      // RELEASE cycle) would otherwise be lost silently, so it is flagged.
      if (w_done_rise && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_done_rise) begin
            r_state   <= READ;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
            r_central <= CENTRAL_L_HAPPENED;
          end
        end
        READ: begin
          if (w_can_issue) begin
            if (is_last_idx(r_rd_addr)) begin
              // Keep the final address on the port once reading is done
              r_state <= FLUSH;
            end else begin
              r_rd_addr <= r_rd_addr + AW'(1);
            end
          end
        end
        FLUSH: begin
          // Words leave strictly in order, so the last one leaving means
          // the pipeline and buffer are both drained
          if (w_pop && w_head.last) begin
            r_state   <= REL;
            r_busy    <= 1'b0;
            r_release <= 1'b1;
          end
        end
        REL: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign RD_RES_ADDR = r_rd_addr;
  assign M_VALID     = !w_fifo_empty;
  assign M_DATA      = w_head.data;
  assign M_IDX       = w_head.idx;
  assign M_LAST      = w_head.last;
  assign M_CENTRAL   = r_central;
  assign BUSY        = r_busy;
  assign RELEASE     = r_release;
  assign OVERRUN     = r_overrun;

endmodule

// File: tb/tb_amq_result_drain.sv
// Directed bench for amq_result_drain: free flow, backpressure, alternating
// ready, centred flag, overrun and reset in the middle of a burst.
module tb_amq_result_drain;
  import amq_pkg::*;

  logic          clk;
  logic          rst;
  logic          done;
  logic          central;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  d_res;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [AW-1:0] m_idx;
  logic          m_last;
  logic          m_central;
  logic          busy;
  logic          rel;
  logic          overrun;

  int errors;
  int checks;

  logic [W-1:0] ram [WORDS];

  // Per-burst observations gathered by drive_burst
  int            n_got;
  int            n_rel;
  int            hold_bad;
  int            outst_bad;
  int            central_bad;
  logic [AW-1:0] got_idx  [8];
  logic [W-1:0]  got_data [8];
  logic          got_last [8];

  amq_result_drain dut (
    .CLK                (clk),
    .RST                (rst),
    .DONE_AmQ           (done),
    .CENTRAL_L_HAPPENED (central),
    .RD_RES_ADDR        (rd_addr),
    .D_RES              (d_res),
    .M_VALID            (m_valid),
    .M_READY            (m_ready),
    .M_DATA             (m_data),
    .M_IDX              (m_idx),
    .M_LAST             (m_last),
    .M_CENTRAL          (m_central),
    .BUSY               (busy),
    .RELEASE            (rel),
    .OVERRUN            (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reducer result RAM: one cycle registered read
  always @(posedge clk) d_res <= ram[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst. Edge 0 is the edge that samples the DONE rise.
  // mode 0: ready always high, 1: ready low until edge 11, 2: alternating.
  task automatic drive_burst(input int mode, input logic cflag, input bit inject_overrun);
    logic          holding;
    logic [W-1:0]  held_data;
    logic [AW-1:0] held_idx;
    int            rel_age;
    n_got = 0; n_rel = 0; hold_bad = 0; outst_bad = 0; central_bad = 0;
    holding = 1'b0; held_data = '0; held_idx = '0; rel_age = 0;
    for (int i = 0; i < 8; i++) begin
      got_idx[i] = 'x; got_data[i] = 'x; got_last[i] = 1'bx;
    end
    done = 1'b1;
    central = cflag;
    for (int e = 0; e < 60; e++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (e >= 11);
        default: m_ready = (e % 2 == 1);
      endcase
      if (e == 1) central = 1'b0;
      if (inject_overrun && e == 3) done = 1'b0;
      if (inject_overrun && e == 4) done = 1'b1;
      if (holding && (!m_valid || m_data !== held_data || m_idx !== held_idx)) hold_bad++;
      if (m_valid && m_ready) begin
        if (n_got < 8) begin
          got_idx[n_got] = m_idx; got_data[n_got] = m_data; got_last[n_got] = m_last;
        end
        if (m_central !== cflag) central_bad++;
        $display("  xfer edge=%0d idx=%0d last=%0b central=%0b data=%h", e, m_idx, m_last, m_central, m_data);
        n_got++;
      end
      holding   = m_valid && !m_ready;
      held_data = m_data;
      held_idx  = m_idx;
      tick();
      if (rel) n_rel++;
      if (int'(rd_addr) > n_got + 2) outst_bad++;
      if (n_rel > 0) rel_age++;
      if (rel_age >= 4) break;
    end
    done = 1'b0;
    central = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; central = 1'b0; m_ready = 1'b0;
    tick(); tick();
    checks++; if (rd_addr !== '0)   begin errors++; $display("FAIL reset_addr: got %0h want 0", rd_addr); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
    checks++; if (m_data !== '0)    begin errors++; $display("FAIL reset_data: got %h want 0", m_data); end
    checks++; if (m_idx !== '0)     begin errors++; $display("FAIL reset_idx: got %0h want 0", m_idx); end
    checks++; if (m_last !== 1'b0)  begin errors++; $display("FAIL reset_last: got %0b want 0", m_last); end
    checks++; if (m_central !== 1'b0) begin errors++; $display("FAIL reset_central: got %0b want 0", m_central); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (rel !== 1'b0)     begin errors++; $display("FAIL reset_release: got %0b want 0", rel); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  // Rise sampled at edge 0 (plan's cycle 10): valid on edges 2..5,
  // RELEASE and BUSY low on edge 6.
  task automatic test_free_flow();
    logic exp_valid;
    m_ready = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ff_idle_busy: got %0b want 0", busy); end
    done = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_valid = (e >= 2 && e <= 5);
      checks++; if (m_valid !== exp_valid) begin errors++; $display("FAIL ff_valid e=%0d: got %0b want %0b", e, m_valid, exp_valid); end
      checks++; if (busy !== (e <= 5)) begin errors++; $display("FAIL ff_busy e=%0d: got %0b want %0b", e, busy, (e <= 5)); end
      checks++; if (rel !== (e == 6)) begin errors++; $display("FAIL ff_release e=%0d: got %0b want %0b", e, rel, (e == 6)); end
      if (exp_valid) begin
        checks++; if (m_idx !== AW'(e - 2)) begin errors++; $display("FAIL ff_idx e=%0d: got %0d want %0d", e, m_idx, e - 2); end
        checks++; if (m_data !== ram[e - 2]) begin errors++; $display("FAIL ff_data e=%0d: got %h want %h", e, m_data, ram[e - 2]); end
        checks++; if (m_last !== (e == 5)) begin errors++; $display("FAIL ff_last e=%0d: got %0b want %0b", e, m_last, (e == 5)); end
      end
      $display("  free_flow edge=%0d valid=%0b idx=%0d last=%0b busy=%0b release=%0b", e, m_valid, m_idx, m_last, busy, rel);
    end
    done = 1'b0;
    tick(); tick();
    $display("test_free_flow done");
  endtask

  task automatic test_backpressure();
    drive_burst(1, 1'b0, 1'b0);
    checks++; if (n_got !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", n_got); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", hold_bad); end
    checks++; if (outst_bad !== 0) begin errors++; $display("FAIL bp_outstanding: got %0d violations want 0", outst_bad); end
    checks++; if (n_rel !== 1) begin errors++; $display("FAIL bp_release: got %0d want 1", n_rel); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_idx[i] !== AW'(i) || got_data[i] !== ram[i] || got_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL bp_word%0d: got idx=%0d last=%0b data=%h want idx=%0d last=%0b data=%h",
                 i, got_idx[i], got_last[i], got_data[i], i, (i == 3), ram[i]);
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_alternating();
    drive_burst(2, 1'b0, 1'b0);
    checks++; if (n_got !== 4) begin errors++; $display("FAIL alt_count: got %0d want 4", n_got); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL alt_stable: got %0d want 0", hold_bad); end
    checks++; if (n_rel !== 1) begin errors++; $display("FAIL alt_release: got %0d want 1", n_rel); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_idx[i] !== AW'(i) || got_data[i] !== ram[i] || got_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL alt_word%0d: got idx=%0d last=%0b data=%h want idx=%0d last=%0b",
                 i, got_idx[i], got_last[i], got_data[i], i, (i == 3));
      end
    end
    $display("test_alternating done");
  endtask

  task automatic test_central();
    drive_burst(0, 1'b1, 1'b0);
    checks++; if (n_got !== 4) begin errors++; $display("FAIL cen1_count: got %0d want 4", n_got); end
    checks++; if (central_bad !== 0) begin errors++; $display("FAIL cen1_flag: got %0d words without M_CENTRAL=1", central_bad); end
    drive_burst(0, 1'b0, 1'b0);
    checks++; if (n_got !== 4) begin errors++; $display("FAIL cen0_count: got %0d want 4", n_got); end
    checks++; if (central_bad !== 0) begin errors++; $display("FAIL cen0_flag: got %0d words without M_CENTRAL=0", central_bad); end
    $display("test_central done");
  endtask

  task automatic test_overrun();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %0b want 0", overrun); end
    drive_burst(0, 1'b0, 1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b want 1", overrun); end
    checks++; if (n_got !== 4) begin errors++; $display("FAIL ovr_count: got %0d want 4", n_got); end
    checks++; if (n_rel !== 1) begin errors++; $display("FAIL ovr_release: got %0d want 1", n_rel); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_idx[i] !== AW'(i) || got_data[i] !== ram[i]) begin
        errors++;
        $display("FAIL ovr_word%0d: got idx=%0d data=%h want idx=%0d data=%h", i, got_idx[i], got_data[i], i, ram[i]);
      end
    end
    tick(); tick(); tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_idle: got busy=%0b want 0", busy); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    int stray;
    seen = 0;
    stray = 0;
    m_ready = 1'b1;
    done = 1'b1;
    // Words 0 and 1 transfer on edges 3 and 4
    for (int e = 0; e <= 4; e++) begin
      if (m_valid && m_ready) seen++;
      tick();
    end
    checks++; if (seen !== 2) begin errors++; $display("FAIL rmb_pre_words: got %0d want 2", seen); end
    rst = 1'b1;
    done = 1'b0;
    tick();
    checks++; if (rd_addr !== '0)     begin errors++; $display("FAIL rmb_addr: got %0h want 0", rd_addr); end
    checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL rmb_valid: got %0b want 0", m_valid); end
    checks++; if (m_data !== '0)      begin errors++; $display("FAIL rmb_data: got %h want 0", m_data); end
    checks++; if (m_idx !== '0)       begin errors++; $display("FAIL rmb_idx: got %0h want 0", m_idx); end
    checks++; if (m_last !== 1'b0)    begin errors++; $display("FAIL rmb_last: got %0b want 0", m_last); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmb_busy: got %0b want 0", busy); end
    checks++; if (rel !== 1'b0)       begin errors++; $display("FAIL rmb_release: got %0b want 0", rel); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rmb_overrun: got %0b want 0", overrun); end
    rst = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (m_valid || rel || busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rmb_quiet: got %0d active cycles want 0", stray); end
    drive_burst(0, 1'b0, 1'b0);
    checks++; if (n_got !== 4) begin errors++; $display("FAIL rmb_restart_count: got %0d want 4", n_got); end
    checks++; if (n_rel !== 1) begin errors++; $display("FAIL rmb_restart_release: got %0d want 1", n_rel); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_idx[i] !== AW'(i) || got_data[i] !== ram[i]) begin
        errors++;
        $display("FAIL rmb_word%0d: got idx=%0d data=%h want idx=%0d data=%h", i, got_idx[i], got_data[i], i, ram[i]);
      end
    end
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    done = 1'b0;
    central = 1'b0;
    m_ready = 1'b0;
    ram[0] = 118'h1;
    ram[1] = 118'h2;
    ram[2] = 118'h3;
    ram[3] = '1;

    test_reset();
    test_free_flow();
    test_backpressure();
    test_alternating();
    test_central();
    test_overrun();
    test_reset_mid_burst();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amq_result_drain.md
Name: amq_result_drain

Overview:
- Sits directly downstream of the A-mod-Q reduction unit, on the lift/scale path.
- When the reducer signals completion, this block reads its multi-word result RAM through the result read-address port. It handles the synchronous read latency and presents the words, LSW first, on a valid/ready stream to the next stage.
- Absorbs downstream backpressure with a small prefetch buffer. Tags the burst with the reducer's centred-lift flag, and pulses a release strobe once the whole result is consumed so the controller can restart the reducer.

Parameters:
- W, 118, result word width in bits
- WORDS, 4, words per reduced result
- AW, 2, result address width (clog2(WORDS))
- RD_LAT, 1, cycles from RD_RES_ADDR to valid D_RES
- BUF_DEPTH, 2, prefetch buffer entries (must be >= RD_LAT+1)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- DONE_AmQ  in  1  reducer completion level; high while result is stable
- CENTRAL_L_HAPPENED  in  1  reducer centred-lift flag, valid while DONE_AmQ is high
- RD_RES_ADDR  out  AW  result RAM word address to reducer
- D_RES  in  W  result word, RD_LAT cycles after address
- M_VALID  out  1  stream word valid
- M_READY  in  1  downstream accept
- M_DATA  out  W  stream word
- M_IDX  out  AW  word index of M_DATA
- M_LAST  out  1  high with the word at index WORDS-1
- M_CENTRAL  out  1  centred flag latched for the current burst
- BUSY  out  1  burst in progress
- RELEASE  out  1  one-cycle pulse after the last word is accepted
- OVERRUN  out  1  sticky error flag

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous, active-high.
- Reset values: RD_RES_ADDR=0, M_VALID=0, M_DATA=0, M_IDX=0, M_LAST=0, M_CENTRAL=0, BUSY=0, RELEASE=0, OVERRUN=0. Buffer is emptied, state is IDLE.
- Burst start: triggered by the rising edge of DONE_AmQ (registered previous value; reset clears it to 0). On that edge, M_CENTRAL latches CENTRAL_L_HAPPENED.
- Transfer rule: a word transfers when M_VALID && M_READY.
- FSM states:
  - IDLE: BUSY=0. On DONE_AmQ rise -> READ, with rd_ptr=0 and BUSY=1.
  - READ: issue the read at rd_ptr only when (buffer occupancy + reads in flight) < BUF_DEPTH; then rd_ptr++. After issuing address WORDS-1 -> FLUSH. RD_RES_ADDR holds its last value when not issuing.
  - FLUSH: wait until all in-flight reads have landed and the buffer is empty, with the last word transferred -> REL.
  - REL: RELEASE=1 for exactly one cycle, BUSY=0, -> IDLE.
- Read pipeline: an RD_LAT-deep valid/index shift register tracks in-flight reads. Data landing at the tail is written into the buffer together with its index.
- Buffer: FIFO of BUF_DEPTH entries. M_DATA, M_IDX and M_LAST come from the head, and M_VALID = not empty. Output is registered from buffer storage, with no combinational path from M_READY to M_DATA.
- Throughput: with M_READY held high, one word per cycle. The first M_VALID occurs RD_LAT+1 cycles after the DONE_AmQ rise, and the last transfer occurs WORDS+RD_LAT cycles after it.
- Backpressure: M_DATA, M_IDX and M_LAST stay stable while M_VALID && !M_READY. No word is lost or duplicated. Reads stall once buffer space is committed.
- Simultaneous buffer push and pop: allowed when full; occupancy is unchanged.
- Ordering: indices are emitted 0..WORDS-1 strictly in order; M_LAST is asserted only at index WORDS-1.
- Overrun: a DONE_AmQ rising edge while BUSY=1 sets OVERRUN (sticky until RST) and is otherwise ignored. The current burst completes normally.
- DONE_AmQ falling mid-burst: no effect on the burst (result RAM contents are held by the reducer until restart).
- RST mid-burst: immediate return to reset values. In-flight reads are discarded and no RELEASE is issued.

Decomposition:
- Shared package (amq_pkg): W, WORDS, AW constants, and the state encoding typedef {IDLE, READ, FLUSH, REL}.
- One natural sub-module: amq_drain_fifo (BUF_DEPTH x (W+AW+1) synchronous FIFO with full/empty/count outputs). The FSM and read pipeline stay in the top.

Test Plan:
- Free-flow: result RAM = {0x1, 0x2, 0x3, 0x3FF..F}, M_READY=1, DONE_AmQ rises at cycle 10 -> M_VALID cycles 12..15, M_IDX 0..3, M_LAST only at cycle 15, RELEASE pulse at cycle 16, BUSY low at cycle 16.
- Backpressure: M_READY=0 for cycles 12..20 then 1 -> M_DATA=0x1 held stable throughout, no more than 2 reads outstanding, all 4 words delivered in order, exactly one RELEASE.
- Alternating M_READY (1,0,1,0...) -> word order 0,1,2,3 preserved with no duplicates; M_LAST coincides with index 3.
- Centred flag: CENTRAL_L_HAPPENED=1 at the DONE_AmQ rise, dropping to 0 the next cycle -> M_CENTRAL=1 for the whole burst. A second burst with the flag at 0 -> M_CENTRAL=0.
- Overrun: second DONE_AmQ rise at word 1 of a burst -> OVERRUN=1 and stays 1; the current burst still delivers 4 words and one RELEASE.
- Reset mid-burst: RST asserted after word 1 transferred -> next cycle all outputs at reset values with no RELEASE. A following DONE_AmQ rise restarts cleanly from index 0.
